// File: rtl/ddr_pkg.sv
// Shared constants for the UART transmit scheduler: byte width and FSM state encoding.
package ddr_pkg;

  localparam int unsigned BYTE_W = 8;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_XFER = 2'd1;
  localparam logic [1:0] ST_GAP  = 2'd2;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first asserted request after ptr, wrapping modulo N.
module rr_arbiter #(
  parameter int unsigned N = 4
) (
  input  logic [N-1:0]         req,
  input  logic [$clog2(N)-1:0] ptr,
  output logic [N-1:0]         gnt,
  output logic [$clog2(N)-1:0] gnt_idx
);

  localparam int unsigned IDX_W = $clog2(N);

  logic [IDX_W-1:0] idx;
  logic             found;

  // Walk ptr+1 .. ptr+N so the last owner is considered last.
  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    idx     = '0;
    found   = 1'b0;
    for (int unsigned i = 1; i <= N; i++) begin
      idx = IDX_W'((32'(ptr) + i) % N);
      if (!found && req[idx]) begin
        found        = 1'b1;
        gnt[idx]     = 1'b1;
        gnt_idx      = idx;
      end
    end
  end

endmodule

// File: rtl/uart_tx_scheduler.sv
// Round-robin, packet-granular sharing of one UART byte stream among N_REQ requesters,
// with a MAX_PKT byte cap per grant and GAP_CYCLES idle cycles between packets.
module uart_tx_scheduler
  import ddr_pkg::*;
#(
  parameter int unsigned N_REQ      = 4,
  parameter int unsigned MAX_PKT    = 32,
  parameter int unsigned GAP_CYCLES = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [N_REQ-1:0]        req_valid,
  input  logic [BYTE_W*N_REQ-1:0] req_data,
  input  logic [N_REQ-1:0]        req_last,
  output logic [N_REQ-1:0]        req_ready,
  output logic [BYTE_W-1:0]       tx_data,
  output logic                    tx_valid,
  input  logic                    tx_ready,
  output logic [N_REQ-1:0]        grant,
  output logic                    busy,
  output logic                    trunc
);

  localparam int unsigned IDX_W = $clog2(N_REQ);
  localparam int unsigned CNT_W = $clog2(MAX_PKT + 1);
  localparam int unsigned GAP_W = (GAP_CYCLES > 0) ? $clog2(GAP_CYCLES + 1) : 1;

  logic [1:0]       state_q,    state_d;
  logic [N_REQ-1:0] grant_q,    grant_d;
  logic [IDX_W-1:0] owner_q,    owner_d;
  logic [IDX_W-1:0] rr_ptr_q,   rr_ptr_d;
  logic [CNT_W-1:0] byte_cnt_q, byte_cnt_d;
  logic [GAP_W-1:0] gap_cnt_q,  gap_cnt_d;
  logic             trunc_q,    trunc_d;

  logic [N_REQ-1:0] arb_gnt;
  logic [IDX_W-1:0] arb_idx;
  logic             xfer;
  logic             beat;
  logic             last_byte;
  logic             cap_hit;

  rr_arbiter #(.N(N_REQ)) u_arb (
    .req     (req_valid),
    .ptr     (rr_ptr_q),
    .gnt     (arb_gnt),
    .gnt_idx (arb_idx)
  );

  assign grant = grant_q;
  assign trunc = trunc_q;
  assign busy  = (state_q != ST_IDLE);

  // Unbuffered pass-through from the current owner to the serializer.
  always_comb begin
    xfer      = (state_q == ST_XFER);
    tx_valid  = xfer & req_valid[owner_q];
    req_ready = xfer ? (grant_q & {N_REQ{tx_ready}}) : '0;
    tx_data   = '0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      if (owner_q == IDX_W'(i)) tx_data = req_data[i*BYTE_W +: BYTE_W];
    end
  end

  assign beat      = tx_valid & tx_ready;
  assign last_byte = req_last[owner_q];
  assign cap_hit   = (byte_cnt_q == CNT_W'(MAX_PKT - 1));

  always_comb begin
    state_d    = state_q;
    grant_d    = grant_q;
    owner_d    = owner_q;
    rr_ptr_d   = rr_ptr_q;
    byte_cnt_d = byte_cnt_q;
    gap_cnt_d  = gap_cnt_q;
    trunc_d    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (|req_valid) begin
          grant_d    = arb_gnt;
          owner_d    = arb_idx;
          rr_ptr_d   = arb_idx;
          byte_cnt_d = '0;
          state_d    = ST_XFER;
        end
      end
      ST_XFER: begin
        if (beat) begin
          byte_cnt_d = byte_cnt_q + CNT_W'(1);
          // A real last on the capped byte is a normal end, not a truncation.
          if (last_byte || cap_hit) begin
            trunc_d    = ~last_byte;
            grant_d    = '0;
            byte_cnt_d = '0;
            gap_cnt_d  = '0;
            state_d    = (GAP_CYCLES != 0) ? ST_GAP : ST_IDLE;
          end
        end
      end
      ST_GAP: begin
        gap_cnt_d = gap_cnt_q + GAP_W'(1);
        if (gap_cnt_q == GAP_W'(GAP_CYCLES - 1)) begin
          gap_cnt_d = '0;
          state_d   = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
        grant_d = '0;
      end
    endcase
  end

  // Reset leaves requester 0 as the first to be served.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      grant_q    <= '0;
      owner_q    <= '0;
      rr_ptr_q   <= IDX_W'(N_REQ - 1);
      byte_cnt_q <= '0;
      gap_cnt_q  <= '0;
      trunc_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      grant_q    <= grant_d;
      owner_q    <= owner_d;
      rr_ptr_q   <= rr_ptr_d;
      byte_cnt_q <= byte_cnt_d;
      gap_cnt_q  <= gap_cnt_d;
      trunc_q    <= trunc_d;
    end
  end

endmodule
